// File: rtl/dmem_responder.sv
// Memory-side responder for CPU lw/sw: one 16-bit word access per req/ack
// handshake, with WAIT_STATES cycles between request capture and the access.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;

    logic [15:0] mem [DEPTH];

    logic          a_we;
    logic [15:0]   a_addr;
    logic [15:0]   a_wdata;
    logic          a_bad;
    logic [AW-1:0] a_idx;
    logic          access;

    // With zero wait states the access happens on the capture edge itself,
    // so the operands come straight from the inputs while still in IDLE.
    always_comb begin
        if (state_q == S_IDLE) begin
            a_we    = we;
            a_addr  = addr;
            a_wdata = wdata;
        end else begin
            a_we    = we_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
        end
        a_bad  = (a_addr[1:0] != 2'b00) || (32'(a_addr[15:2]) >= DEPTH);
        a_idx  = a_addr[2 +: AW];
        access = ((state_q == S_IDLE) && req && (WAIT_STATES == 0))
              || ((state_q == S_WAIT) && (cnt_q == '0));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (WAIT_STATES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            if (access) begin
                err_q   <= a_bad;
                rdata_q <= (a_we || a_bad) ? '0 : mem[a_idx];
            end
        end
    end

    // The array has no reset; a reset before the access edge leaves state_q
    // out of WAIT/IDLE-with-req, so the write never fires.
    always_ff @(posedge clock) begin
        if (access && a_we && !a_bad) begin
            mem[a_idx] <= a_wdata;
        end
    end

    assign ack   = (state_q == S_RESP);
    assign busy  = (state_q != S_IDLE);
    assign err   = err_q & ack;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table on a 2-wait-state
// instance plus hand sequences for back-to-back, reset and capture cases.
module tb_dmem_responder;

    logic        clock;
    logic        reset_n;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic        ack, err, busy;
    logic [15:0] rdata;
    logic        req0, we0;
    logic [15:0] addr0, wdata0;
    logic        ack0, err0, busy0;
    logic [15:0] rdata0;

    int nerr = 0;
    int nchk = 0;

    logic [15:0] exp_mem [1024];

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xact(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic e, output int lat);
        @(negedge clock);
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!ack && lat < 20);
        rd  = rdata;
        e   = err;
        req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [15:0] rd;
        logic        e;
        int          lat;
        int          bad;
        int          acks;

        vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 16'h0005, 1'b0};
        vecs[1]  = '{1'b0, 16'h0004, 16'h0000, 16'h0007, 1'b0};
        vecs[2]  = '{1'b1, 16'h0000, 16'h0007, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 16'h0004, 16'h0005, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 16'h0004, 16'h0000, 16'h0005, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h0007, 1'b0};
        vecs[6]  = '{1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 16'h1000, 16'hDEAD, 16'h0000, 1'b1};
        vecs[8]  = '{1'b1, 16'h0003, 16'hBEEF, 16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 16'hFFFC, 16'h0000, 16'h0000, 1'b1};
        vecs[10] = '{1'b0, 16'h0FFC, 16'h0000, 16'h59FF, 1'b0};
        vecs[11] = '{1'b0, 16'h0008, 16'h0000, 16'h1234, 1'b0};

        reset_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;

        for (int i = 0; i < 1024; i++) exp_mem[i] = 16'(i) ^ 16'h5A00;
        exp_mem[0] = 16'h0005;
        exp_mem[1] = 16'h0007;
        exp_mem[2] = 16'h1234;
        for (int i = 0; i < 1024; i++) u_dut.mem[i] = exp_mem[i];

        #1;
        chk("reset_ack",   32'(ack),   32'h0);
        chk("reset_err",   32'(err),   32'h0);
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk("reset_busy",  32'(busy),  32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Table on the 2-wait-state instance.
        for (int i = 0; i < 12; i++) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, e, lat);
            chk($sformatf("v%0d_rdata", i), 32'(rd),  32'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_err", i),   32'(e),   32'(vecs[i].exp_err));
            chk($sformatf("v%0d_lat", i),   32'(lat), 32'd3);
            if (vecs[i].we && !vecs[i].exp_err) exp_mem[vecs[i].addr[11:2]] = vecs[i].wdata;
        end

        @(negedge clock);
        chk("post_ack",        32'(ack),   32'h0);
        chk("post_err",        32'(err),   32'h0);
        chk("post_rdata_hold", 32'(rdata), 32'h1234);

        bad = 0;
        for (int i = 0; i < 1024; i++) if (u_dut.mem[i] !== exp_mem[i]) bad++;
        chk("array_readback_bad_words", 32'(bad), 32'd0);
        chk("swap_mem0", 32'(u_dut.mem[0]), 32'h0007);
        chk("swap_mem1", 32'(u_dut.mem[1]), 32'h0005);

        // Reset while in WAIT abandons the write.
        @(negedge clock);
        req = 1'b1; we = 1'b1; addr = 16'h0008; wdata = 16'hBEEF;
        @(negedge clock);
        chk("wait_busy", 32'(busy), 32'h1);
        chk("wait_ack",  32'(ack),  32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_ack",   32'(ack),   32'h0);
        chk("midrst_busy",  32'(busy),  32'h0);
        chk("midrst_rdata", 32'(rdata), 32'h0);
        chk("midrst_err",   32'(err),   32'h0);
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (ack) acks++;
        end
        chk("midrst_no_ack", 32'(acks), 32'd0);
        chk("midrst_mem2",   32'(u_dut.mem[2]), 32'h1234);

        // Inputs changed during WAIT must not affect the access.
        @(negedge clock);
        req = 1'b1; we = 1'b1; addr = 16'h000C; wdata = 16'h1111;
        @(negedge clock);
        we = 1'b0; addr = 16'h0010; wdata = 16'h2222;
        lat = 1;
        while (!ack && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk("cap_lat",   32'(lat),   32'd3);
        chk("cap_err",   32'(err),   32'h0);
        chk("cap_rdata", 32'(rdata), 32'h0);
        req = 1'b0;
        @(negedge clock);
        chk("cap_mem3", 32'(u_dut.mem[3]), 32'h1111);
        chk("cap_mem4", 32'(u_dut.mem[4]), 32'(exp_mem[4]));

        // Zero wait states with req held high for three writes.
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0000; wdata0 = 16'hA000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk($sformatf("b2b_ack%0d", i),  32'(ack0),  32'((i % 2) == 0));
            chk($sformatf("b2b_busy%0d", i), 32'(busy0), 32'((i % 2) == 0));
            if (ack0) begin
                chk($sformatf("b2b_err%0d", i), 32'(err0), 32'h0);
                addr0  = addr0 + 16'd4;
                wdata0 = wdata0 + 16'd1;
                if (i == 4) req0 = 1'b0;
            end
        end
        chk("b2b_mem0", 32'(u_dut0.mem[0]), 32'hA000);
        chk("b2b_mem1", 32'(u_dut0.mem[1]), 32'hA001);
        chk("b2b_mem2", 32'(u_dut0.mem[2]), 32'hA002);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
